// File: rtl/complex_mult_host.sv
// complex_mult_host: buffers operand pairs from a cmd stream, issues them one at a
// time to a complex multiplier, forwards each result downstream and supervises a
// per-transaction response timeout.
module complex_mult_host #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sw_rst,
    input  logic                      cmd_val,
    output logic                      cmd_ready,
    input  logic [4*DATA_WIDTH-1:0]   cmd_data,
    output logic                      op_val,
    input  logic                      op_ready,
    output logic [4*DATA_WIDTH-1:0]   op_data,
    input  logic                      res_val,
    output logic                      res_ready,
    input  logic [4*DATA_WIDTH+2:0]   res_data,
    output logic                      out_val,
    input  logic                      out_ready,
    output logic [4*DATA_WIDTH+2:0]   out_data,
    output logic [15:0]               issued_cnt,
    output logic [15:0]               done_cnt,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int unsigned OP_W  = 4 * DATA_WIDTH;
    localparam int unsigned RES_W = 4 * DATA_WIDTH + 3;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    state_t             state_q,       state_d;
    logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]   count_q,       count_d;
    logic [TMR_W-1:0]   timer_q,       timer_d;
    logic [RES_W-1:0]   res_q,         res_d;
    logic [15:0]        issued_cnt_q,  issued_cnt_d;
    logic [15:0]        done_cnt_q,    done_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic [OP_W-1:0]    mem_q [FIFO_DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // A software clear suppresses any handshake in the same cycle.
    assign push  = cmd_val && !full && !sw_rst;
    assign pop   = (state_q == ISSUE) && op_ready && !sw_rst;

    // Operand storage; data only, pointers carry the reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    // Next-state: FIFO bookkeeping, transaction FSM, counters, sticky timeout.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        timer_d       = timer_q;
        res_d         = res_q;
        issued_cnt_d  = issued_cnt_q;
        done_cnt_d    = done_cnt_q;
        timeout_err_d = timeout_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    issued_cnt_d = issued_cnt_q + 16'd1;
                    timer_d      = '0;
                    state_d      = WAIT_RES;
                end
            end
            WAIT_RES: begin
                timer_d = timer_q + TMR_W'(1);
                if (res_val) begin
                    res_d      = res_data;
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = DELIVER;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            DELIVER: begin
                if (out_ready) begin
                    state_d = empty ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sw_rst) begin
            state_d       = IDLE;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            timer_d       = '0;
            res_d         = '0;
            issued_cnt_d  = '0;
            done_cnt_d    = '0;
            timeout_err_d = 1'b0;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            res_q         <= '0;
            issued_cnt_q  <= '0;
            done_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            res_q         <= res_d;
            issued_cnt_q  <= issued_cnt_d;
            done_cnt_q    <= done_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Handshake strobes decode from the state register only.
    assign op_val      = (state_q == ISSUE);
    assign res_ready   = (state_q == WAIT_RES);
    assign out_val     = (state_q == DELIVER);
    assign op_data     = mem_q[rd_ptr_q];
    assign out_data    = res_q;
    assign cmd_ready   = !full;
    assign issued_cnt  = issued_cnt_q;
    assign done_cnt    = done_cnt_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_complex_mult_host.sv
// tb_complex_mult_host: randomized and directed checks of complex_mult_host against
// a queue-based reference model and a 2-cycle multiplier responder.
module tb_complex_mult_host;

    logic        clk = 1'b0;
    logic        rst, sw_rst, cmd_val, op_ready, out_ready, stray_res;
    logic [31:0] cmd_data;
    logic        cmd_ready, op_val, res_ready, out_val, timeout_err, busy;
    logic [31:0] op_data;
    logic [34:0] out_data;
    logic [15:0] issued_cnt, done_cnt;
    logic        res_val_m = 1'b0;
    logic [34:0] res_data_m = '0;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] cmd_q[$];
    logic [34:0] exp_res = '0;
    int          n_out = 0;
    bit          answer_en = 1'b1;
    int          res_cnt = -1;
    logic [31:0] mul_op = '0;

    always #5 clk = ~clk;

    complex_mult_host #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst),
        .cmd_val(cmd_val), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
        .res_val(res_val_m | stray_res), .res_ready(res_ready), .res_data(res_data_m),
        .out_val(out_val), .out_ready(out_ready), .out_data(out_data),
        .issued_cnt(issued_cnt), .done_cnt(done_cnt),
        .timeout_err(timeout_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference complex product {pad, re, im} from signed 8-bit components.
    function automatic logic [34:0] cmul(input logic [31:0] p);
        int a, b, c, d, re, im;
        a  = int'($signed(p[31:24]));
        b  = int'($signed(p[23:16]));
        c  = int'($signed(p[15:8]));
        d  = int'($signed(p[7:0]));
        re = a * c - b * d;
        im = a * d + b * c;
        return {3'b000, re[15:0], im[15:0]};
    endfunction

    // Scoreboard plus multiplier responder; samples pre-edge values, drives after the edge.
    always begin
        bit c_hs, o_hs, r_hs, u_hs, clr;
        logic [31:0] head;
        @(posedge clk);
        clr  = rst || sw_rst;
        c_hs = cmd_val && cmd_ready;
        o_hs = op_val && op_ready;
        r_hs = (res_val_m || stray_res) && res_ready;
        u_hs = out_val && out_ready;
        if (clr) begin
            cmd_q.delete();
            res_cnt = -1;
        end else begin
            if (res_cnt > 0) res_cnt--;
            if (o_hs) begin
                if (cmd_q.size() == 0) begin
                    check("op_unexpected", 64'(1), 64'(0));
                end else begin
                    head = cmd_q.pop_front();
                    check("op_data_order", 64'(op_data), 64'(head));
                    exp_res = cmul(head);
                end
                mul_op = op_data;
                if (answer_en) res_cnt = 2;
            end
            if (c_hs) cmd_q.push_back(cmd_data);
            if (u_hs) begin
                check("out_data_sb", 64'(out_data), 64'(exp_res));
                n_out++;
            end
        end
        #1;
        if (clr || r_hs) res_val_m = 1'b0;
        if (!clr && res_cnt == 0) begin
            res_val_m  = 1'b1;
            res_data_m = cmul(mul_op);
            res_cnt    = -1;
        end
    end

    task automatic push_cmd(input logic [31:0] d);
        bit acc = 1'b0;
        cmd_val  = 1'b1;
        cmd_data = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(posedge clk);
            acc = cmd_ready;
            @(negedge clk);
        end
        cmd_val = 1'b0;
        if (!acc) check("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_outs(input int target);
        for (int i = 0; i < 3000 && n_out < target; i++) @(negedge clk);
        check("drain_count", 64'(n_out), 64'(target));
    endtask

    task automatic wait_out_val();
        for (int i = 0; i < 200 && !out_val; i++) @(negedge clk);
        check("out_val_seen", 64'(out_val), 64'(1));
    endtask

    task automatic wait_res_ready();
        for (int i = 0; i < 200 && !res_ready; i++) @(negedge clk);
        check("res_ready_seen", 64'(res_ready), 64'(1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_op_val"},      64'(op_val),      64'(0));
        check({tag, "_res_ready"},   64'(res_ready),   64'(0));
        check({tag, "_out_val"},     64'(out_val),     64'(0));
        check({tag, "_cmd_ready"},   64'(cmd_ready),   64'(1));
        check({tag, "_issued"},      64'(issued_cnt),  64'(0));
        check({tag, "_done"},        64'(done_cnt),    64'(0));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
        check({tag, "_busy"},        64'(busy),        64'(0));
        check({tag, "_out_data"},    64'(out_data),    64'(0));
    endtask

    initial begin
        int exp_issued, exp_done, exp_out, acc, cyc, sent;
        logic [31:0] p0, p1;
        rst = 1'b1; sw_rst = 1'b0; cmd_val = 1'b0; cmd_data = '0;
        op_ready = 1'b1; out_ready = 1'b1; stray_res = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("por");

        // Single op and issue latency.
        cmd_val = 1'b1; cmd_data = 32'h0304_0506;
        @(negedge clk);
        cmd_val = 1'b0;
        check("lat_op_val_early", 64'(op_val), 64'(0));
        @(negedge clk);
        check("lat_op_val", 64'(op_val), 64'(1));
        check("lat_op_data", 64'(op_data), 64'h0304_0506);
        wait_out_val();
        check("single_out_data", 64'(out_data), 64'h0_FFF7_0026);
        wait_outs(1);
        exp_issued = 1; exp_done = 1; exp_out = 1;
        check("single_issued", 64'(issued_cnt), 64'(exp_issued));
        check("single_done", 64'(done_cnt), 64'(exp_done));

        // Backpressure: five pushes against a stalled multiplier.
        op_ready = 1'b0; acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_val = 1'b1; cmd_data = $urandom;
            @(posedge clk);
            if (cmd_ready) acc++;
            @(negedge clk);
            if (i == 3) check("bp_full_ready", 64'(cmd_ready), 64'(0));
        end
        cmd_val = 1'b0;
        check("bp_accepted", 64'(acc), 64'(4));
        op_ready = 1'b1;
        exp_out += 4; exp_issued += 4; exp_done += 4;
        wait_outs(exp_out);
        check("bp_issued", 64'(issued_cnt), 64'(exp_issued));
        check("bp_queue_empty", 64'(cmd_q.size()), 64'(0));

        // Downstream stall holds DELIVER.
        out_ready = 1'b0;
        p0 = $urandom; p1 = $urandom;
        push_cmd(p0);
        push_cmd(p1);
        wait_out_val();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_val", 64'(out_val), 64'(1));
            check("stall_out_data", 64'(out_data), 64'(cmul(p0)));
            check("stall_res_ready", 64'(res_ready), 64'(0));
            check("stall_op_val", 64'(op_val), 64'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_next_op_val", 64'(op_val), 64'(1));
        check("stall_next_op_data", 64'(op_data), 64'(p1));
        exp_out += 2; exp_issued += 2; exp_done += 2;
        wait_outs(exp_out);

        // Timeout after exactly 64 cycles in WAIT_RES.
        answer_en = 1'b0;
        push_cmd($urandom);
        wait_res_ready();
        cyc = 0;
        while (!timeout_err && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("to_cycles", 64'(cyc), 64'(64));
        check("to_idle_busy", 64'(busy), 64'(0));
        check("to_res_ready", 64'(res_ready), 64'(0));
        exp_issued += 1;
        answer_en = 1'b1;
        p0 = $urandom;
        push_cmd(p0);
        wait_out_val();
        check("to_recover_data", 64'(out_data), 64'(cmul(p0)));
        exp_out += 1; exp_issued += 1; exp_done += 1;
        wait_outs(exp_out);
        check("to_sticky", 64'(timeout_err), 64'(1));
        check("to_issued", 64'(issued_cnt), 64'(exp_issued));
        check("to_done", 64'(done_cnt), 64'(exp_done));

        // Randomized traffic with random back-pressure on both sides.
        sent = 0;
        for (int c = 0; c < 3000 && sent < 30; c++) begin
            op_ready  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cmd_val   = ($urandom_range(0, 1) == 1);
            cmd_data  = $urandom;
            @(posedge clk);
            if (cmd_val && cmd_ready) sent++;
            @(negedge clk);
        end
        cmd_val = 1'b0; op_ready = 1'b1; out_ready = 1'b1;
        check("rand_sent", 64'(sent), 64'(30));
        exp_out += 30; exp_issued += 30; exp_done += 30;
        wait_outs(exp_out);
        check("rand_issued", 64'(issued_cnt), 64'(exp_issued));
        check("rand_done", 64'(done_cnt), 64'(exp_done));

        // Software clear in WAIT_RES with three pairs queued.
        answer_en = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd($urandom);
        wait_res_ready();
        check("mid_busy", 64'(busy), 64'(1));
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        check_reset_state("swrst");
        stray_res = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_out_val", 64'(out_val), 64'(0));
            check("stray_done", 64'(done_cnt), 64'(0));
            check("stray_cmd_ready", 64'(cmd_ready), 64'(1));
        end
        stray_res = 1'b0;
        answer_en = 1'b1;
        exp_out = n_out;

        // Counter wrap from a preloaded 0xFFFF.
        force dut.issued_cnt_q = 16'hFFFF;
        force dut.done_cnt_q   = 16'hFFFF;
        #1;
        release dut.issued_cnt_q;
        release dut.done_cnt_q;
        @(negedge clk);
        check("wrap_preload", 64'(issued_cnt), 64'hFFFF);
        push_cmd($urandom);
        exp_out += 1;
        wait_outs(exp_out);
        check("wrap_issued", 64'(issued_cnt), 64'(0));
        check("wrap_done", 64'(done_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/complex_mult_host.md
Name: complex_mult_host

Overview:
- Initiator for the complex multiplier operand/result interface. It drives op_val/op_data toward the multiplier and accepts res_val/res_data back.
- Upstream operand pairs arrive on a cmd stream and are buffered in a FIFO. Each pair is issued to the multiplier, one transaction at a time.
- Each result is captured, forwarded on an out stream, and counted. A per-transaction timeout is also supervised.

Parameters:
- DATA_WIDTH, 8, width of each real/imaginary operand component.
- FIFO_DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- TIMEOUT, 64, max cycles in WAIT_RES before the transaction is abandoned; at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- sw_rst  in  1  synchronous software clear, active high
- cmd_val  in  1  upstream operand pair valid
- cmd_ready  out  1  FIFO can accept a pair
- cmd_data  in  4*DATA_WIDTH  {op1_re, op1_im, op2_re, op2_im}, MSB first
- op_val  out  1  operand pair valid toward multiplier
- op_ready  in  1  multiplier ready for operands
- op_data  out  4*DATA_WIDTH  FIFO head, same packing as cmd_data
- res_val  in  1  multiplier result valid
- res_ready  out  1  host ready to take result
- res_data  in  4*DATA_WIDTH+3  multiplier result {pad, re, im}
- out_val  out  1  captured result valid downstream
- out_ready  in  1  downstream accepts result
- out_data  out  4*DATA_WIDTH+3  captured res_data, unmodified
- issued_cnt  out  16  completed op handshakes
- done_cnt  out  16  completed res handshakes
- timeout_err  out  1  sticky; a transaction timed out
- busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (rst=1 async, or sw_rst=1 at the clock edge):
  - state=IDLE; FIFO empty; pointers 0; timer 0.
  - Result register 0; counters 0; timeout_err 0.
  - All val outputs 0; cmd_ready=1.
  - sw_rst has priority over every other event in that cycle.
- Reset mid-transaction drops the in-flight pair and the buffered pairs. No out_val is produced for them.
- FIFO:
  - Push on cmd_val & cmd_ready; cmd_ready = !full.
  - Pop on op_val & op_ready.
  - Push and pop in the same cycle are both allowed when not full; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_val while full is ignored; the data is not written.
- FSM states: IDLE, ISSUE, WAIT_RES, DELIVER.
  - IDLE: FIFO not empty -> ISSUE.
  - ISSUE: op_val=1, op_data=FIFO head, held stable until handshake. op_val & op_ready -> pop, issued_cnt++, timer=0, -> WAIT_RES.
  - WAIT_RES: res_ready=1; timer increments each cycle.
    - res_val & res_ready -> capture res_data, done_cnt++, -> DELIVER.
    - Otherwise, timer == TIMEOUT-1 -> timeout_err=1, -> IDLE; that pair is dropped.
    - If res_val arrives in the same cycle as the timer expiry, the result wins.
  - DELIVER: out_val=1, out_data=captured value. out_ready -> go to ISSUE if the FIFO is not empty, else IDLE.
- Output timing:
  - op_val, res_ready and out_val are decoded from state only, never from same-cycle inputs.
  - res_ready=0 outside WAIT_RES; res_val outside WAIT_RES is ignored.
- Latency: a cmd accepted at edge N gives op_val high after edge N+1, when the FSM was idle with an empty FIFO.
- At most one outstanding transaction.
- Counters wrap 0xFFFF -> 0x0000.
- timeout_err is cleared only by rst or sw_rst.

Test Plan (DATA_WIDTH=8, bench multiplier model answers 2 cycles after op handshake):
- Single op: cmd 0x03040506 (3+4j)*(5+6j) -> op_data=0x03040506 one cycle after cmd handshake. Model returns re=0xFFF7 (-9), im=0x0026. out_data=35'h0_FFF7_0026; issued_cnt=done_cnt=1.
- Backpressure: push 5 pairs with op_ready=0 -> cmd_ready drops after the 4th push and the 5th is not accepted. Then release op_ready, out_ready=1 -> exactly 4 results in push order; issued_cnt=4.
- Downstream stall: out_ready=0 for 10 cycles in DELIVER -> out_val and out_data stable. res_ready=0 and no new op_val meanwhile; release -> next pair issued the following cycle.
- Timeout: model never answers -> timeout_err=1 after exactly 64 WAIT_RES cycles, state IDLE. Next pair still processes normally; timeout_err stays 1.
- Reset mid-operation: sw_rst in WAIT_RES with 3 pairs queued -> next cycle all outputs at reset values. A later res_val is ignored; cmd_ready=1.
- Counter wrap: preload by 65535 transactions (or force), one more -> issued_cnt=0x0000, done_cnt=0x0000.
